// File: rtl/end_screen_pkg.sv
// Shared constants for the end-of-race screen: player indices, colour masks,
// animation mode encodings and the winner-tracking FSM state type.
package end_screen_pkg;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  // Masks are ordered {G,R,B}
  localparam logic [2:0] MASK_GREEN  = 3'b100;
  localparam logic [2:0] MASK_RED    = 3'b010;
  localparam logic [2:0] MASK_BLUE   = 3'b001;
  localparam logic [2:0] MASK_YELLOW = 3'b110;

  localparam int MODE_STEADY = 0;
  localparam int MODE_BLINK  = 1;
  localparam int MODE_PULSE  = 2;

  typedef enum logic {WAIT, WON} state_e;

  function automatic logic [2:0] color_mask(input logic [1:0] id);
    case (id)
      GREEN:   return MASK_GREEN;
      RED:     return MASK_RED;
      BLUE:    return MASK_BLUE;
      default: return MASK_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/end_screen_animator_if.sv
// Control, position and intensity-chain signals of the end-screen animator.
interface end_screen_animator_if #(
  parameter int NB_PLAYERS = 4,
  parameter int POS_W      = 7
);
  logic                        enable;
  logic                        new_game;
  logic [NB_PLAYERS*POS_W-1:0] pos_bus;
  logic [7:0]                  i_red_intensity;
  logic [7:0]                  i_blue_intensity;
  logic [7:0]                  i_green_intensity;
  logic [7:0]                  o_red_intensity;
  logic [7:0]                  o_blue_intensity;
  logic [7:0]                  o_green_intensity;
  logic                        o_winner_valid;
  logic [1:0]                  o_winner_id;

  modport master (
    output enable, new_game, pos_bus,
    output i_red_intensity, i_blue_intensity, i_green_intensity,
    input  o_red_intensity, o_blue_intensity, o_green_intensity,
    input  o_winner_valid, o_winner_id
  );

  modport slave (
    input  enable, new_game, pos_bus,
    input  i_red_intensity, i_blue_intensity, i_green_intensity,
    output o_red_intensity, o_blue_intensity, o_green_intensity,
    output o_winner_valid, o_winner_id
  );
endinterface

// File: rtl/anim_level_gen.sv
// Animation level generator: tick counter plus blink phase or pulse ramp.
// level_o is the level the registers will hold after the coming edge.
module anim_level_gen
  import end_screen_pkg::*;
#(
  parameter int MODE        = 1,
  parameter int INTENSITY   = 5,
  parameter int BLINK_TICKS = 12_000_000,
  parameter int STEP_TICKS  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic [7:0] level_o
);
  localparam int TICKS = (MODE == MODE_PULSE) ? STEP_TICKS : BLINK_TICKS;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             down_q, down_d;
  logic [7:0]       lvl_q, lvl_d;
  logic             wrap;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    down_d  = down_q;
    lvl_d   = lvl_q;
    wrap    = (cnt_q == CNT_W'(TICKS - 1));
    if (!run_i) begin
      // Holding at zero makes every re-enable start from ON / level 0
      cnt_d   = '0;
      phase_d = 1'b0;
      down_d  = 1'b0;
      lvl_d   = 8'd0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        phase_d = ~phase_q;
        if (!down_q) begin
          lvl_d = lvl_q + 8'd1;
          if (lvl_q + 8'd1 == 8'(INTENSITY)) down_d = 1'b1;
        end else begin
          lvl_d = lvl_q - 8'd1;
          if (lvl_q == 8'd1) down_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    level_o = 8'd0;
    case (MODE)
      MODE_STEADY: level_o = 8'(INTENSITY);
      MODE_BLINK:  level_o = phase_d ? 8'd0 : 8'(INTENSITY);
      MODE_PULSE:  level_o = lvl_d;
      default:     level_o = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      down_q  <= 1'b0;
      lvl_q   <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      down_q  <= down_d;
      lvl_q   <= lvl_d;
    end
  end
endmodule

// File: rtl/pipe_tri_bus.sv
// Screen-chain stage mux: drives this screen's colours when enabled, otherwise
// forwards the upstream intensities with zero latency.
module pipe_tri_bus (
  input  logic       enable_i,
  input  logic [7:0] anim_red_i,
  input  logic [7:0] anim_green_i,
  input  logic [7:0] anim_blue_i,
  input  logic [7:0] up_red_i,
  input  logic [7:0] up_green_i,
  input  logic [7:0] up_blue_i,
  output logic [7:0] out_red_o,
  output logic [7:0] out_green_o,
  output logic [7:0] out_blue_o
);
  assign out_red_o   = enable_i ? anim_red_i   : up_red_i;
  assign out_green_o = enable_i ? anim_green_i : up_green_i;
  assign out_blue_o  = enable_i ? anim_blue_i  : up_blue_i;
endmodule

// File: rtl/end_screen_animator.sv
// End-of-race screen: latches the first finisher and animates its colour,
// forwarding the upstream intensity chain when not selected.
module end_screen_animator
  import end_screen_pkg::*;
#(
  parameter int MAX_POS     = 109,
  parameter int NB_PLAYERS  = 4,
  parameter int POS_W       = $clog2(MAX_POS),
  parameter int MODE        = 1,
  parameter int INTENSITY   = 5,
  parameter int BLINK_TICKS = 12_000_000,
  parameter int STEP_TICKS  = 1_000_000
) (
  input logic clk,
  input logic rst,
  end_screen_animator_if.slave bus
);
  if (MODE < 0 || MODE > 2 || NB_PLAYERS < 1 || NB_PLAYERS > 4) begin : g_bad_param
    $error("end_screen_animator: illegal MODE or NB_PLAYERS");
  end

  state_e                state_q, state_d;
  logic [1:0]            winner_q, winner_d;
  logic [NB_PLAYERS-1:0] finish;
  logic [1:0]            first_idx;
  logic                  run;
  logic [7:0]            level;
  logic [2:0]            mask;
  logic [7:0]            red_q, red_d, green_q, green_d, blue_q, blue_d;

  for (genvar gi = 0; gi < NB_PLAYERS; gi++) begin : g_finish
    assign finish[gi] = (bus.pos_bus[gi*POS_W +: POS_W] == POS_W'(MAX_POS - 1));
  end

  // Scan downwards so the lowest finishing index is the one kept
  always_comb begin
    first_idx = 2'd0;
    for (int k = NB_PLAYERS - 1; k >= 0; k--) begin
      if (finish[k]) first_idx = 2'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      WAIT: begin
        if (!bus.new_game && (|finish)) begin
          state_d  = WON;
          winner_d = first_idx;
        end
      end
      WON: begin
        if (bus.new_game) begin
          state_d  = WAIT;
          winner_d = 2'd0;
        end
      end
      default: begin
        state_d  = WAIT;
        winner_d = 2'd0;
      end
    endcase
  end

  assign run = bus.enable && (state_q == WON) && !bus.new_game;

  anim_level_gen #(
    .MODE        (MODE),
    .INTENSITY   (INTENSITY),
    .BLINK_TICKS (BLINK_TICKS),
    .STEP_TICKS  (STEP_TICKS)
  ) u_level (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .level_o (level)
  );

  // Colour registers track the post-edge state so they line up with o_winner_valid
  always_comb begin
    mask    = color_mask(winner_d);
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    if (state_d == WON) begin
      green_d = mask[2] ? level : 8'd0;
      red_d   = mask[1] ? level : 8'd0;
      blue_d  = mask[0] ? level : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT;
      winner_q <= 2'd0;
      red_q    <= 8'd0;
      green_q  <= 8'd0;
      blue_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign bus.o_winner_valid = (state_q == WON);
  assign bus.o_winner_id    = winner_q;

  pipe_tri_bus u_mux (
    .enable_i     (bus.enable),
    .anim_red_i   (red_q),
    .anim_green_i (green_q),
    .anim_blue_i  (blue_q),
    .up_red_i     (bus.i_red_intensity),
    .up_green_i   (bus.i_green_intensity),
    .up_blue_i    (bus.i_blue_intensity),
    .out_red_o    (bus.o_red_intensity),
    .out_green_o  (bus.o_green_intensity),
    .out_blue_o   (bus.o_blue_intensity)
  );
endmodule

// File: doc/end_screen_animator.md
Name: end_screen_animator

Overview:
Successor to the static end-of-race screen. Latches the first player to reach the finish LED and holds that winner until the next game. Drives the winner's colour with a steady, blinking or pulsing (triangle-fade) animation. Sits in the screen manager chain and passes the upstream intensity bus through unchanged when not enabled, using the existing pipe_tri_bus.

Parameters:
MAX_POS, 109, number of LEDs on the strip; finish position is MAX_POS-1
NB_PLAYERS, 4, number of players, legal range 1..4; player index order is green, red, blue, yellow
POS_W, $clog2(MAX_POS), width of one position field
MODE, 1, animation mode: 0 = steady, 1 = blink, 2 = pulse
INTENSITY, 5, peak intensity per lit colour channel (8-bit, 1..255)
BLINK_TICKS, 12_000_000, clk cycles per blink half-period (ON or OFF), minimum 1
STEP_TICKS, 1_000_000, clk cycles per +/-1 intensity step in pulse mode, minimum 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  screen selected; high = this block drives the bus
new_game  in  1  single-cycle pulse; clears the latched winner
pos_bus  in  NB_PLAYERS*POS_W  packed positions; player k occupies bits [k*POS_W +: POS_W]
i_red_intensity  in  8  upstream red
i_blue_intensity  in  8  upstream blue
i_green_intensity  in  8  upstream green
o_red_intensity  out  8  red to the next stage
o_blue_intensity  out  8  blue to the next stage
o_green_intensity  out  8  green to the next stage
o_winner_valid  out  1  a winner is latched
o_winner_id  out  2  index of the latched winner

Behaviour:
- Clock: one clock, clk. Reset: rst, synchronous, active-high.
- On rst: FSM goes to WAIT; o_winner_valid=0; o_winner_id=0; tick counter, phase and level all 0.
- WAIT state:
  - Each cycle, compare every player's position with MAX_POS-1.
  - If one or more players match, the lowest index wins.
  - On a match, latch the winner id and go to WON on the next edge. o_winner_valid=1 at N+1 when the match occurs in cycle N.
- WON state:
  - Positions are ignored; later finishers never change the winner.
  - new_game=1 returns the FSM to WAIT, clears the winner, counters and level. Outputs are cleared at the next edge.
  - new_game and a finish in the same cycle while in WAIT: new_game wins, no latch.
  - rst has priority over everything.
- Winner detection runs regardless of enable.
- Animation counters advance only while enable=1 and state is WON. Otherwise they are held at 0, so the animation restarts in the ON phase (blink) or at level 0 (pulse) whenever enable rises.
- Colour mask for the winner:
  - green: G=1, R=0, B=0
  - red: R=1, G=0, B=0
  - blue: B=1, G=0, R=0
  - yellow: G=1, R=1, B=0
- Per-mode level applied to each masked channel; unmasked channels are 0:
  - MODE 0: level = INTENSITY.
  - MODE 1: the tick counter counts 0..BLINK_TICKS-1 and wraps. The phase toggles on the wrap. Level = INTENSITY when phase=0 (ON), else 0. The first ON half-period lasts exactly BLINK_TICKS cycles after enable.
  - MODE 2: the tick counter counts 0..STEP_TICKS-1. On wrap, level moves one step in the current direction. Direction reverses on reaching INTENSITY (going up) and on reaching 0 (going down). Level never leaves the range 0..INTENSITY. Full period = 2*INTENSITY*STEP_TICKS cycles.
- In WAIT, the driven intensities are 0.
- Output mux (pipe_tri_bus, combinational):
  - enable=1: o_* = the registered animated intensities.
  - enable=0: o_* = i_*, zero latency.
- The animated intensities are registered: 1 cycle from the counter/state change to the output.
- Illegal MODE or NB_PLAYERS is an elaboration error (generate-time check).

Decomposition:
- Package end_screen_pkg:
  - player index localparams: GREEN=0, RED=1, BLUE=2, YELLOW=3
  - colour-mask constants, ordered {G,R,B}
  - MODE encodings: MODE_STEADY, MODE_BLINK, MODE_PULSE
  - FSM state enum {WAIT, WON}
- Sub-modules:
  - existing pipe_tri_bus for the output mux
  - one new sub-module, anim_level_gen: mode, tick counter, phase/direction and level register; produces the 8-bit level.

Test Plan:
1. Reset, MODE=0, enable=1; set green pos=108 at cycle 5 -> o_winner_valid=1 and o_green=5 at cycle 6; o_red=o_blue=0.
2. red and blue both set to 108 in the same cycle -> o_winner_id=1 (red); blue reaching 108 later causes no change.
3. MODE=1, BLINK_TICKS=4, yellow wins, enable=1 -> G=R=5 for 4 cycles, then 0 for 4 cycles, repeating; drop enable then raise it -> the sequence restarts in the ON phase.
4. MODE=2, INTENSITY=3, STEP_TICKS=2 -> level sequence 0,1,2,3,2,1,0,1..., each value held 2 cycles; never exceeds 3.
5. enable=0 with i_red=7, i_green=9, i_blue=11 -> outputs equal the inputs in the same cycle, whatever the winner state.
6. new_game asserted in the same cycle a finish occurs in WAIT -> no latch. new_game in WON -> o_winner_valid=0 and outputs 0 at the next edge. rst in mid-blink -> WAIT, all registers 0.
